// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Serialises a DATA_WIDTH-bit parallel word into one frame:
//   start bit (0), data bits LSB first, optional parity bit, stop bit (1).
//   One bit is sent per CLK cycle, so CLK runs at the bit rate. The parity bit
//   has the same polarity the UART RX path checks, so a looped-back frame is
//   received without a parity error.
//
// Ports
//   CLK         in   1           bit-rate clock, all logic on posedge
//   RST         in   1           synchronous, active-high reset
//   P_DATA      in   DATA_WIDTH  word to send, sampled only on acceptance
//   Data_Valid  in   1           request to send P_DATA (pulse or level)
//   PAR_EN      in   1           1 = append parity bit, sampled on acceptance
//   PAR_TYP     in   1           0 = even, 1 = odd parity, sampled on acceptance
//   TX_OUT      out  1           serial line, registered, idles high
//   busy        out  1           registered, high while a frame is on the line
//   state_dbg   out  3           current FSM state, for observation only
//
// Handshake: a request is accepted at the posedge where Data_Valid=1 while the
//   FSM is in IDLE (equivalently busy=0 and RST=0). Requests in any other cycle
//   are dropped, not queued. ~busy is therefore the "ready" for the upstream.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_q;     // shifted right as bits go out
    logic                  par_en_q;
    logic                  par_bit_q;

    assign state_dbg = state;

    // TX_OUT is always loaded with the value for the state being entered, so
    // the line shows a bit in the same cycle the FSM sits in that bit's state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        // even: XOR of the data, odd: its complement
                        par_bit_q <= PAR_TYP ? ~(^P_DATA) : (^P_DATA);
                        bit_cnt   <= '0;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    TX_OUT  <= data_q[0];
                    data_q  <= data_q >> 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit_q;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        TX_OUT  <= data_q[0];
                        data_q  <= data_q >> 1;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: begin
                    // busy drops together with the return to IDLE, which
                    // guarantees at least one idle-high cycle between frames
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
